stopwatch_display_mux: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/bcd_to_seg.sv | 32 +++
 rtl/stopwatch_display_mux.sv | 121 ++++++++++++
 tb/tb_stopwatch_display_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_pkg                                                   |
// | Brief    : Shared glyphs, digit index type and adjust-field encodings      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package stopwatch_pkg;

  // Segment vectors are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef logic [1:0] digit_idx_t;

  // Digit slot that carries the MM:SS separator
  localparam digit_idx_t DP_IDX = 2'd2;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_SEC  = 2'b01;
  localparam logic [1:0] ADJ_MIN  = 2'b10;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_to_seg                                                      |
// | Brief    : Combinational BCD to active-low 7-segment decoder, blank for >9 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/stopwatch_display_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_display_mux                                           |
// | Brief    : Scans four BCD digits (MM:SS) onto a common-anode 4-digit       |
// |            seven-segment display. Define DISPLAY_BLINK_EN to blink the     |
// |            field chosen by adj_sel.                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module stopwatch_display_mux
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [1:0] adj_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int c_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [c_PRE_W-1:0] r_prescaler;
  logic               w_scan_tick;
  digit_idx_t         r_idx;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg;
  logic [3:0]         w_an_scan;
  logic [3:0]         w_an_gate;

  assign w_scan_tick = (r_prescaler == c_PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler <= '0;
      r_idx       <= 2'd0;
    end else begin
      if (w_scan_tick) begin
        r_prescaler <= '0;
        r_idx       <= r_idx + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + c_PRE_W'(1);
      end
    end
  end

  always_comb begin
    w_digit = sec_ones;
    case (r_idx)
      2'd0: w_digit = sec_ones;
      2'd1: w_digit = sec_tens;
      2'd2: w_digit = min_ones;
      2'd3: w_digit = min_tens;
      default: w_digit = sec_ones;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (w_digit),
    .seg (w_seg)
  );

  assign w_an_scan = ~(4'b0001 << r_idx);

`ifdef DISPLAY_BLINK_EN
  localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [c_BLK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  // Free-running: adjust-field changes never restart the blink phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == c_BLK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + c_BLK_W'(1);
    end
  end

  always_comb begin
    w_an_gate = 4'b0000;
    if (r_blink_phase) begin
      case (adj_sel)
        ADJ_SEC: w_an_gate = 4'b0011;
        ADJ_MIN: w_an_gate = 4'b1100;
        default: w_an_gate = 4'b0000;
      endcase
    end
  end
`else
  logic w_unused_adj;

  assign w_unused_adj = ^adj_sel;
  assign w_an_gate    = 4'b0000;
`endif

  // Gating only darkens anodes; segment and dp drive stay untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_an_scan | w_an_gate;
      seg <= w_seg;
      dp  <= (r_idx == DP_IDX) ? 1'b0 : 1'b1;
    end
  end

endmodule : stopwatch_display_mux
`default_nettype wire

// File: tb/tb_stopwatch_display_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stopwatch_display_mux                                        |
// | Brief    : Scoreboard bench for stopwatch_display_mux, REFRESH_DIV=4,      |
// |            BLINK_DIV=16; honours DISPLAY_BLINK_EN when defined.            |
// | Revision : 1.1  direct output checks added                                 |
// +----------------------------------------------------------------------------+
module tb_stopwatch_display_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [1:0] adj_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    stopwatch_display_mux #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .adj_sel  (adj_sel),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    typedef struct {
        int         edge_no;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push(input int e, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input string nm);
        exp_t x;
        x.edge_no = e; x.an = a; x.seg = s; x.dp = d; x.name = nm;
        q.push_back(x);
    endtask

    // Expected output at edge e of a scan whose first post-reset edge is 'start'
    task automatic push_scan(input int e, input int start, input int d0, input int d1,
                             input int d2, input int d3, input logic [1:0] adj,
                             input string nm);
        int         slot;
        int         dg;
        logic [3:0] a;
        slot = ((e - start) / 4) % 4;
        case (slot)
            0: begin a = 4'b1110; dg = d0; end
            1: begin a = 4'b1101; dg = d1; end
            2: begin a = 4'b1011; dg = d2; end
            default: begin a = 4'b0111; dg = d3; end
        endcase
`ifdef DISPLAY_BLINK_EN
        if ((((e - start) / 16) % 2) == 1) begin
            if (adj == 2'b01) a = a | 4'b0011;
            if (adj == 2'b10) a = a | 4'b1100;
        end
`endif
        push(e, a, glyph(dg), (slot == 2) ? 1'b0 : 1'b1, nm);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: outputs are presented every edge; compare whatever is due
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].edge_no <= cyc) begin
                x = q.pop_front();
                chk_cnt++;
                if (x.edge_no == cyc && an === x.an && seg === x.seg && dp === x.dp) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s edge=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b (due edge %0d)",
                             x.name, cyc, an, seg, dp, x.an, x.seg, x.dp, x.edge_no);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        sec_ones = 4'd1; sec_tens = 4'd2; min_ones = 4'd3; min_tens = 4'd4;
        adj_sel  = 2'b00;
        for (int e = 1; e <= 3; e++) push(e, 4'b1111, 7'b1111111, 1'b1, "reset_dark");

        wait_until(3);
        chk_cnt++;
        if (an === 4'b1111 && seg === 7'b1111111 && dp === 1'b1) begin
            pass_cnt++;
        end else begin
            $display("FAIL direct_reset_dark: got an=%b seg=%b dp=%b", an, seg, dp);
        end
        reset    = 1'b0;
        sec_ones = 4'd4; sec_tens = 4'd3; min_ones = 4'd2; min_tens = 4'd1;
        for (int e = 4; e <= 20; e++) push_scan(e, 4, 4, 3, 2, 1, 2'b00, "scan_order");

        @(negedge clk);
        chk_cnt++;
        if (an === 4'b1110 && seg === glyph(4) && dp === 1'b1) begin
            pass_cnt++;
        end else begin
            $display("FAIL direct_first_digit: got an=%b seg=%b dp=%b", an, seg, dp);
        end

        // One new value per cycle inside index-0 windows (edges 36.., 52.., 68.., 84..)
        for (int v = 0; v < 16; v++) begin
            if (v % 4 == 0) wait_until(4 + 16 * (2 + v / 4) - 1);
            sec_ones = v[3:0];
            push(cyc + 1, 4'b1110, glyph(v), 1'b1, "decode_sweep");
            @(negedge clk);
        end

        // Index 2 is displayed on edges 108..111, so the index register holds 2 here
        wait_until(108);
        reset    = 1'b1;
        sec_ones = 4'd7;
        push(109, 4'b1111, 7'b1111111, 1'b1, "midscan_reset");
        @(negedge clk);
        chk_cnt++;
        if (an === 4'b1111 && seg === 7'b1111111 && dp === 1'b1) begin
            pass_cnt++;
        end else begin
            $display("FAIL direct_midscan_reset: got an=%b seg=%b dp=%b", an, seg, dp);
        end
        reset   = 1'b0;
        adj_sel = 2'b01;
        for (int e = 110; e <= 173; e++) push_scan(e, 110, 7, 3, 2, 1, 2'b01, "adj_sec");

        wait_until(173);
        adj_sel = 2'b10;
        for (int e = 174; e <= 237; e++) push_scan(e, 110, 7, 3, 2, 1, 2'b10, "adj_min");

        wait_until(237);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk_cnt++;
            $display("FAIL %s timeout: edge %0d never checked, got none, want an=%b",
                     x.name, x.edge_no, x.an);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_stopwatch_display_mux
`default_nettype wire
